rgb_fade_pwm: RTL and testbench

//   Downstream stage of the colour-sequencing FSM. Takes its on/off red/green/blue

---
 rtl/rgb_pkg.sv | 20 ++
 rtl/fade_channel.sv | 62 ++++++
 rtl/rgb_fade_pwm.sv | 81 ++++++++
 tb/tb_rgb_fade_pwm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and defaults for the RGB crossfade PWM stage.
package rgb_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int NUM_CH       = 3;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_idx_e;

  // Counter width for an interval, never narrower than one bit.
  function automatic int step_cnt_width(input int interval);
    return (interval > 1) ? $clog2(interval) : 1;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// One colour channel: level ramp toward an on/off target, per-period duty shadow
// and registered PWM compare.
module fade_channel #(
  parameter int PWM_BITS  = rgb_pkg::PWM_BITS_DEF,
  parameter int MAX_LEVEL = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                target_on,
  input  logic                tick,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX_L  = PWM_BITS'(MAX_LEVEL);
  localparam logic [PWM_BITS-1:0] ZERO_L = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] ONE_L  = PWM_BITS'(1);

  logic [PWM_BITS-1:0] target_s;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

  // Next-state for level, duty shadow and output compare.
  always_comb begin
    target_s = target_on ? MAX_L : ZERO_L;
    level_d  = level_q;
    if (tick && (level_q < target_s)) begin
      level_d = level_q + ONE_L;
    end else if (tick && (level_q > target_s)) begin
      level_d = level_q - ONE_L;
    end else begin
      level_d = level_q;
    end
    // Duty only follows the level at the period boundary so a period is never split.
    if (wrap) begin
      duty_d = level_q;
    end else begin
      duty_d = duty_q;
    end
    pwm_d = (duty_q > pwm_cnt);
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= ZERO_L;
      duty_q  <= ZERO_L;
      pwm_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm       = pwm_q;
  assign at_target = (level_q == target_s);

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB crossfade PWM: shared period/step timebase, three fading channels and a
// registered busy flag raised while any channel is still ramping.
module rgb_fade_pwm #(
  parameter int PWM_BITS      = rgb_pkg::PWM_BITS_DEF,
  parameter int STEP_INTERVAL = 4688,
  parameter int MAX_LEVEL     = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic pwm_r,
  output logic pwm_g,
  output logic pwm_b,
  output logic busy
);

  import rgb_pkg::*;

  localparam int SC_W = step_cnt_width(STEP_INTERVAL);
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_INTERVAL - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SC_W-1:0]     step_cnt_q, step_cnt_d;
  logic                busy_q, busy_d;
  logic                tick_s, wrap_s;
  logic [NUM_CH-1:0]   on_s, pwm_s, at_target_s;

  assign on_s[CH_R] = red_in;
  assign on_s[CH_G] = green_in;
  assign on_s[CH_B] = blue_in;

  // Timebase decode and busy aggregation.
  always_comb begin
    wrap_s    = (pwm_cnt_q == {PWM_BITS{1'b1}});
    tick_s    = (step_cnt_q == STEP_LAST);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    if (tick_s) begin
      step_cnt_d = {SC_W{1'b0}};
    end else begin
      step_cnt_d = step_cnt_q + SC_W'(1);
    end
    busy_d = ~(&at_target_s);
  end

  // Timebase and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q  <= {PWM_BITS{1'b0}};
      step_cnt_q <= {SC_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      busy_q     <= busy_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .MAX_LEVEL (MAX_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .target_on (on_s[ch]),
      .tick      (tick_s),
      .wrap      (wrap_s),
      .pwm_cnt   (pwm_cnt_q),
      .pwm       (pwm_s[ch]),
      .at_target (at_target_s[ch])
    );
  end

  assign pwm_r = pwm_s[CH_R];
  assign pwm_g = pwm_s[CH_G];
  assign pwm_b = pwm_s[CH_B];
  assign busy  = busy_q;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Directed plus random bench for rgb_fade_pwm against an arithmetic cycle model.
module tb_rgb_fade_pwm;

  localparam int PB  = 4;
  localparam int SI  = 3;
  localparam int ML  = 15;
  localparam int PER = 16;

  logic clk = 1'b0;
  logic rst, red_in, green_in, blue_in;
  logic pwm_r, pwm_g, pwm_b, busy;

  always #5 clk = ~clk;

  rgb_fade_pwm #(
    .PWM_BITS      (PB),
    .STEP_INTERVAL (SI),
    .MAX_LEVEL     (ML)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .red_in   (red_in),
    .green_in (green_in),
    .blue_in  (blue_in),
    .pwm_r    (pwm_r),
    .pwm_g    (pwm_g),
    .pwm_b    (pwm_b),
    .busy     (busy)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   lvl  [3];
  int   duty [3];
  logic exp_pwm [3];
  logic exp_busy;

  // Model: cycles since reset give the PWM phase and tick times directly.
  task automatic model_edge();
    int   tgt;
    int   cnt;
    logic any;
    logic ins [3];
    ins[0] = red_in;
    ins[1] = green_in;
    ins[2] = blue_in;
    if (rst) begin
      cyc = 0;
      exp_busy = 1'b0;
      for (int c = 0; c < 3; c++) begin
        lvl[c] = 0; duty[c] = 0; exp_pwm[c] = 1'b0;
      end
    end else begin
      cnt = cyc % PER;
      any = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tgt = ins[c] ? ML : 0;
        exp_pwm[c] = (duty[c] > cnt);
        if (lvl[c] != tgt) any = 1'b1;
        if (cnt == PER - 1) duty[c] = lvl[c];
        if (cyc % SI == SI - 1) begin
          if (lvl[c] < tgt) lvl[c] = lvl[c] + 1;
          else if (lvl[c] > tgt) lvl[c] = lvl[c] - 1;
        end
      end
      exp_busy = any;
      cyc = cyc + 1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pwm_r", pwm_r, exp_pwm[0]);
    check("pwm_g", pwm_g, exp_pwm[1]);
    check("pwm_b", pwm_b, exp_pwm[2]);
    check("busy", busy, exp_busy);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=reached", tag);
  endtask

  task automatic align_period();
    for (int k = 0; k < PER && (cyc % PER) != 0; k++) step();
  endtask

  task automatic count_period(input int ch, output int hi);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      if (ch == 0 && pwm_r === 1'b1) hi++;
      if (ch == 1 && pwm_g === 1'b1) hi++;
      if (ch == 2 && pwm_b === 1'b1) hi++;
    end
  endtask

  initial begin
    int k;
    int hi;
    int d_exp;
    rst = 1'b1; red_in = 1'b1; green_in = 1'b1; blue_in = 1'b1;

    // 1: reset with all targets on
    step();
    check("rst_pwm_r", pwm_r, 1'b0);
    check("rst_busy", busy, 1'b0);
    step();
    check("rst_pwm_g", pwm_g, 1'b0);
    check("rst_pwm_b", pwm_b, 1'b0);
    rst = 1'b0;
    step();
    check("busy_after_release", busy, 1'b1);

    // 2: red ramp to full, then 15/16 duty
    green_in = 1'b0; blue_in = 1'b0;
    do_reset(1);
    repeat (45) step();
    check("ramp_busy_last", busy, 1'b1);
    step();
    check("ramp_busy_drop", busy, 1'b0);
    align_period();
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      check("full_duty_bit", pwm_r, (i != PER - 1) ? 1'b1 : 1'b0);
      if (pwm_r === 1'b1) hi++;
    end
    check_int("full_duty_count", hi, 15);

    // 3: idle after reset
    red_in = 1'b0;
    do_reset(1);
    repeat (64) begin
      step();
      check("idle_r", pwm_r, 1'b0);
      check("idle_g", pwm_g, 1'b0);
      check("idle_b", pwm_b, 1'b0);
      check("idle_busy", busy, 1'b0);
    end

    // 4: reversal at level 8, no underflow
    do_reset(1);
    red_in = 1'b1;
    for (k = 0; k < 200 && lvl[0] != 8; k++) step();
    if (k >= 200) timeout("rev_reach8");
    red_in = 1'b0;
    repeat (8 * SI + 2 * PER) step();
    repeat (32) begin
      step();
      check("rev_hold_zero", pwm_r, 1'b0);
      check("rev_busy", busy, 1'b0);
    end

    // 5: shadow - levels move mid-period, duty changes only at wrap
    red_in = 1'b1;
    align_period();
    count_period(0, hi);
    d_exp = duty[0];
    count_period(0, hi);
    check_int("shadow_cur", hi, d_exp);
    d_exp = duty[0];
    count_period(0, hi);
    check_int("shadow_next", hi, d_exp);

    // 6: reset during a green ramp
    red_in = 1'b0; green_in = 1'b1;
    do_reset(1);
    for (k = 0; k < 200 && lvl[1] != 7; k++) step();
    if (k >= 200) timeout("g_reach7");
    rst = 1'b1;
    step();
    check("rst_mid_pwm_g", pwm_g, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (45) step();
    check("restart_busy_last", busy, 1'b1);
    step();
    check("restart_busy_drop", busy, 1'b0);

    // Random targets with occasional reset
    repeat (900) begin
      if ($urandom_range(0, 11) == 0) begin
        red_in   = 1'($urandom_range(0, 1));
        green_in = 1'($urandom_range(0, 1));
        blue_in  = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
